// File: rtl/mode_sequencer_pkg.sv
// mode_sequencer_pkg: network mode constants and sequencer state encoding shared with the neuron layers
package mode_sequencer_pkg;
  localparam logic MODE_TRAIN = 1'b1;
  localparam logic MODE_TEST = 1'b0;
  typedef enum logic [2:0] {IDLE, TRAIN, DRAIN_T, TEST, DRAIN_E, DONE} state_t;
endpackage

// File: rtl/mode_sequencer.sv
// mode_sequencer: gates the sample stream through TRAIN/TEST epochs and keeps mode stable while samples are in flight
module mode_sequencer
  import mode_sequencer_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int NTRAIN = 8,
  parameter int NTEST = 4,
  parameter int NEPOCH = 2,
  parameter int MAXOUT = 4
) (
  input  logic                          iCLK,
  input  logic                          iRST,
  input  logic                          iStart,
  output logic                          oMode,
  output logic                          oBusy,
  output logic                          oDone,
  output logic                          oError,
  output logic [$clog2(NEPOCH+1)-1:0]   oEpoch,
  input  logic                          iValid_AM,
  output logic                          oReady_AM,
  input  logic [WIDTH-1:0]              iData_AM,
  output logic                          oValid_BM,
  input  logic                          iReady_BM,
  output logic [WIDTH-1:0]              oData_BM,
  input  logic                          iValid_Res,
  input  logic                          iReady_Res
);
  localparam int PW = $clog2((NTRAIN > NTEST ? NTRAIN : NTEST) + 1);
  localparam int OW = $clog2(MAXOUT + 1);
  localparam int EW = $clog2(NEPOCH + 1);
  state_t state, stateNext;
  logic [PW-1:0] phaseCnt, nPhase;
  logic [OW-1:0] outst;
  logic [EW-1:0] epochInc;
  logic admit, accept, complete, lastAccept;
  // admission gating, handshakes and next-state selection
  always_comb begin
    nPhase = state == TRAIN ? PW'(NTRAIN) : PW'(NTEST);
    admit = (state == TRAIN || state == TEST) && phaseCnt < nPhase && outst < OW'(MAXOUT);
    oValid_BM = iValid_AM & admit;
    oReady_AM = iReady_BM & admit;
    oData_BM = iData_AM;
    accept = iValid_AM & oReady_AM;
    complete = iValid_Res & iReady_Res;
    lastAccept = accept && phaseCnt == nPhase - 1'b1;
    epochInc = oEpoch + 1'b1;
    stateNext = state;
    case (state)
      IDLE: stateNext = iStart ? TRAIN : IDLE;
      TRAIN: stateNext = lastAccept ? DRAIN_T : TRAIN;
      DRAIN_T: stateNext = outst == '0 ? TEST : DRAIN_T;
      TEST: stateNext = lastAccept ? DRAIN_E : TEST;
      DRAIN_E: stateNext = outst != '0 ? DRAIN_E : epochInc == EW'(NEPOCH) ? DONE : TRAIN;
      DONE: stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
    oBusy = state != IDLE && state != DONE;
    oDone = state == DONE;
  end
  // state register, phase/epoch counters, in-flight count and sticky underflow error
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state <= IDLE;
      oMode <= MODE_TEST;
      oEpoch <= '0;
      phaseCnt <= '0;
      outst <= '0;
      oError <= 1'b0;
    end else begin
      state <= stateNext;
      if (stateNext != state && (stateNext == TRAIN || stateNext == TEST)) begin
        phaseCnt <= '0;
        oMode <= stateNext == TRAIN ? MODE_TRAIN : MODE_TEST;
      end else if (accept) begin
        phaseCnt <= phaseCnt + 1'b1;
      end
      if (state == IDLE && iStart) oEpoch <= '0;
      else if (state == DRAIN_E && outst == '0) oEpoch <= epochInc;
      if (accept && !complete) outst <= outst + 1'b1;
      else if (complete && !accept) begin
        if (outst == '0) oError <= 1'b1;
        else outst <= outst - 1'b1;
      end
    end
  end
endmodule

// File: doc/mode_sequencer.md
MODE_SEQUENCER -- requirements
Module: mode_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default 16: width of the gated sample data bus.
REQ-002 SHALL have parameter NTRAIN, default 8: samples admitted per epoch in TRAIN mode; legal range >= 1.
REQ-003 SHALL have parameter NTEST, default 4: samples admitted per epoch in TEST mode; legal range >= 1.
REQ-004 SHALL have parameter NEPOCH, default 2: number of epochs per run; legal range >= 1.
REQ-005 SHALL have parameter MAXOUT, default 4: maximum number of samples in flight in the network; legal range >= 1.
REQ-006 SHALL have the port iCLK, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-007 SHALL have the port iRST, input, 1 bit: reset, synchronous and active-high.
REQ-008 SHALL have the port iStart, input, 1 bit: run request, sampled only in IDLE.
REQ-009 SHALL have the port oMode, output, 1 bit: network mode, TRAIN or TEST, driven to every neuron layer.
REQ-010 SHALL have the ports oBusy, oDone and oError, outputs, 1 bit each: run active; 1-cycle end-of-run pulse; sticky protocol error.
REQ-011 SHALL have the port oEpoch, output, $clog2(NEPOCH+1) bits: count of completed epochs.
REQ-012 SHALL have the ports iValid_AM (input, 1), oReady_AM (output, 1) and iData_AM (input, WIDTH): upstream sample stream.
REQ-013 SHALL have the ports oValid_BM (output, 1), iReady_BM (input, 1) and oData_BM (output, WIDTH): gated stream into the network.
REQ-014 SHALL have the ports iValid_Res and iReady_Res, inputs, 1 bit each: network-output handshake, observe-only.

Function
REQ-015 SHALL implement the states IDLE, TRAIN, DRAIN_T, TEST, DRAIN_E and DONE.
REQ-016 SHALL go from IDLE to TRAIN on iStart=1, and SHALL ignore iStart in every other state.
REQ-017 SHALL define admit = (state is TRAIN or TEST) and phase_cnt < N_phase and outst < MAXOUT, where N_phase is NTRAIN in TRAIN and NTEST in TEST.
REQ-018 SHALL drive oValid_BM = iValid_AM & admit, oReady_AM = iReady_BM & admit, and oData_BM = iData_AM, combinationally with zero latency.
REQ-019 SHALL define accept = iValid_AM & oReady_AM and complete = iValid_Res & iReady_Res.
REQ-020 SHALL increment phase_cnt on each accept and clear it on entering TRAIN or TEST.
REQ-021 SHALL update outst as outst + accept - complete; accept and complete in the same cycle SHALL leave it unchanged.
REQ-022 SHALL, on complete with outst=0 and no accept in that cycle, keep outst at 0 and set oError; oError SHALL hold until reset.
REQ-023 SHALL go from TRAIN to DRAIN_T in the cycle after the NTRAIN-th accept.
REQ-024 SHALL go from DRAIN_T to TEST when outst=0.
REQ-025 SHALL go from TEST to DRAIN_E in the cycle after the NTEST-th accept.
REQ-026 SHALL, in DRAIN_E with outst=0, increment oEpoch, then go to DONE if the new value equals NEPOCH, else to TRAIN.
REQ-027 SHALL register oMode: TRAIN on entry to the TRAIN state, TEST on entry to the TEST state, and unchanged in drain states, so oMode never changes while outst > 0.
REQ-028 SHALL assert oBusy in every state except IDLE and DONE.
REQ-029 SHALL assert oDone for exactly one cycle in DONE, then return to IDLE with oEpoch kept until the next iStart clears it.
REQ-030 SHALL make the first admit possible in the cycle after iStart is sampled.

Reset
REQ-031 SHALL, on iRST=1 at a clock edge, force state=IDLE, oMode=TEST, oEpoch=0, phase_cnt=0, outst=0, oBusy=0, oDone=0 and oError=0.
REQ-032 SHALL force oValid_BM=0 and oReady_AM=0 in the cycle after reset, including when reset occurs mid-run; in-flight samples SHALL be forgotten.

Structure
REQ-033 SHALL take the TRAIN/TEST mode constants and the state encoding from the shared mode/parameter header also used by the neuron layers.
REQ-034 SHALL be a single module with no sub-modules; the counters and FSM are inline.

Verification
REQ-035 Bench SHALL cover: NTRAIN=2, NTEST=1, NEPOCH=1, MAXOUT=4, always-ready sink, results 3 cycles after each accept -> oMode TRAIN for 2 accepts, TEST after the drain, oDone pulse, oEpoch=1.
REQ-036 Bench SHALL cover: MAXOUT=2, results withheld -> exactly 2 accepts, then oReady_AM=0 until a complete, after which 1 more accept.
REQ-037 Bench SHALL cover: accept and complete in the same cycle with outst=1 -> outst stays 1.
REQ-038 Bench SHALL cover: complete pulse in IDLE -> oError=1 and stays 1 until iRST.
REQ-039 Bench SHALL cover: iRST asserted in TEST with outst=3 -> next cycle state IDLE, oMode=TEST, oValid_BM=0, oEpoch=0.
REQ-040 Bench SHALL cover: NEPOCH=3 with iStart held high throughout -> oEpoch 1, 2, 3 with TRAIN/TEST alternation and a single run with one oDone.
